// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared scheduler states and sample/symbol constants for the OFDM transmit path
package ofdm_tx_pkg;
  localparam int SC_NUM = 48;
  localparam int SMP_W = 8;
  localparam int GAP_CYC_DEF = 80;
  typedef enum logic [2:0] {IDLE, INIT, FILL, BURST, GAP, DONE} sched_state_t;
endpackage

// File: rtl/ofdm_sym_buf.sv
// ofdm_sym_buf: 1- or 2-bank 48x16 symbol buffer, write port plus registered read port
module ofdm_sym_buf
  import ofdm_tx_pkg::*;
#(
  parameter int NB = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic               i_wbank,
  input  logic [5:0]         i_waddr,
  input  logic [2*SMP_W-1:0] i_wdata,
  input  logic               i_rbank,
  input  logic [5:0]         i_raddr,
  output logic [2*SMP_W-1:0] o_rdata
);
  localparam int AW = $clog2(NB * SC_NUM);
  logic [2*SMP_W-1:0] r_mem [NB*SC_NUM];
  logic [AW-1:0] w_wa, w_ra;
  assign w_wa = AW'(i_waddr) + ((NB > 1 && i_wbank) ? AW'(SC_NUM) : '0);
  assign w_ra = AW'(i_raddr) + ((NB > 1 && i_rbank) ? AW'(SC_NUM) : '0);
  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_wa] <= i_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) o_rdata <= '0;
    else o_rdata <= r_mem[w_ra];
  end
endmodule

// File: rtl/ofdm_sym_sched.sv
// ofdm_sym_sched: buffers 48-sample data symbols and replays each as one gap-free pilot-inserter burst
// OFDM_SYM_SCHED_OVERLAP_EN: two-bank buffer so the next symbol fills during burst and gap
module ofdm_sym_sched
  import ofdm_tx_pkg::*;
#(
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int SYM_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frm_start,
  input  logic [SYM_W-1:0] frm_nsym,
  input  logic             map_vld,
  input  logic [SMP_W-1:0] map_re,
  input  logic [SMP_W-1:0] map_im,
  output logic             map_rdy,
  output logic             pilot_start,
  output logic             pilot_en,
  output logic [5:0]       pilot_index,
  output logic [SMP_W-1:0] pilot_din_re,
  output logic [SMP_W-1:0] pilot_din_im,
  output logic [SYM_W-1:0] sym_cnt,
  output logic             busy,
  output logic             frm_done
);
`ifdef OFDM_SYM_SCHED_OVERLAP_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif
  localparam logic [5:0] LAST = 6'(SC_NUM - 1);
  sched_state_t r_state;
  logic [SYM_W-1:0] r_nsym, r_acc;
  logic [5:0] r_wr_ptr;
  logic [7:0] r_gap;
  logic [1:0] r_full;
  logic r_wbank, r_rbank;
  logic [2*SMP_W-1:0] w_rdata;
  logic w_fill_st, w_hs, w_last, w_bank_rdy;
  logic [5:0] w_ra;
  assign w_fill_st = OVL ? (r_state inside {FILL, BURST, GAP}) : (r_state == FILL);
  assign map_rdy = w_fill_st && !r_full[r_wbank] && r_acc != r_nsym;
  assign w_hs = map_vld && map_rdy;
  assign w_last = w_hs && r_wr_ptr == LAST;
  // the read bank is ready if already full or its final beat lands this cycle
  assign w_bank_rdy = r_full[r_rbank] || w_last;
  assign w_ra = (r_state == BURST && pilot_index != LAST) ? pilot_index + 6'd1 : 6'd0;
  assign busy = r_state != IDLE;
  assign pilot_din_re = pilot_en ? w_rdata[2*SMP_W-1:SMP_W] : '0;
  assign pilot_din_im = pilot_en ? w_rdata[SMP_W-1:0] : '0;
  ofdm_sym_buf #(.NB(OVL ? 2 : 1)) u_buf (
    .clk(clk),
    .rst(rst),
    .i_we(w_hs),
    .i_wbank(r_wbank),
    .i_waddr(r_wr_ptr),
    .i_wdata({map_re, map_im}),
    .i_rbank(r_rbank),
    .i_raddr(w_ra),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_nsym <= '0;
      r_acc <= '0;
      r_wr_ptr <= '0;
      r_gap <= '0;
      r_full <= '0;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
      pilot_start <= 1'b0;
      pilot_en <= 1'b0;
      pilot_index <= '0;
      sym_cnt <= '0;
      frm_done <= 1'b0;
    end else begin
      pilot_start <= 1'b0;
      frm_done <= r_state == DONE;
      if (w_hs) r_wr_ptr <= w_last ? 6'd0 : r_wr_ptr + 6'd1;
      if (w_last) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank <= r_wbank ^ OVL;
        r_acc <= r_acc + SYM_W'(1);
      end
      case (r_state)
        IDLE: if (frm_start && !frm_done) begin
          r_nsym <= frm_nsym;
          sym_cnt <= '0;
          r_acc <= '0;
          r_full <= '0;
          r_wbank <= 1'b0;
          r_rbank <= 1'b0;
          r_wr_ptr <= '0;
          pilot_start <= frm_nsym != '0;
          r_state <= frm_nsym == '0 ? DONE : INIT;
        end
        INIT: r_state <= FILL;
        FILL: if (w_bank_rdy) begin
          r_state <= BURST;
          pilot_en <= 1'b1;
          pilot_index <= '0;
        end
        BURST: if (pilot_index == LAST) begin
          pilot_en <= 1'b0;
          pilot_index <= '0;
          sym_cnt <= sym_cnt + SYM_W'(1);
          r_full[r_rbank] <= 1'b0;
          r_rbank <= r_rbank ^ OVL;
          r_gap <= 8'(GAP_CYC);
          r_state <= GAP;
        end else pilot_index <= pilot_index + 6'd1;
        GAP: begin
          r_gap <= r_gap - 8'd1;
          if (r_gap == 8'd1) begin
            if (sym_cnt == r_nsym) r_state <= DONE;
            else if (w_bank_rdy) begin
              r_state <= BURST;
              pilot_en <= 1'b1;
              pilot_index <= '0;
            end else r_state <= FILL;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofdm_sym_sched.sv
// tb_ofdm_sym_sched: randomized frames checked against a queue-based symbol replay model
module tb_ofdm_sym_sched;
  localparam int GAP = 80;
  localparam int SC = 48;
`ifdef OFDM_SYM_SCHED_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, frm_start = 1'b0, map_vld = 1'b0;
  logic [7:0] frm_nsym = '0, map_re = '0, map_im = '0;
  logic map_rdy, pilot_start, pilot_en, busy, frm_done;
  logic [5:0] pilot_index;
  logic [7:0] pilot_din_re, pilot_din_im, sym_cnt;
  int n_chk = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  ofdm_sym_sched #(.GAP_CYC(GAP), .SYM_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .frm_start(frm_start),
    .frm_nsym(frm_nsym),
    .map_vld(map_vld),
    .map_re(map_re),
    .map_im(map_im),
    .map_rdy(map_rdy),
    .pilot_start(pilot_start),
    .pilot_en(pilot_en),
    .pilot_index(pilot_index),
    .pilot_din_re(pilot_din_re),
    .pilot_din_im(pilot_din_im),
    .sym_cnt(sym_cnt),
    .busy(busy),
    .frm_done(frm_done)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_ctl"}, {map_rdy, pilot_start, pilot_en, busy, frm_done, pilot_index}, 0);
    check({tag, "_dat"}, {sym_cnt, pilot_din_re, pilot_din_im}, 0);
  endtask
  function automatic logic [15:0] gen(input int vmode, input int n);
    logic [7:0] b;
    b = 8'(n);
    return vmode == 0 ? {b, 8'(-b)} : 16'($urandom);
  endfunction
  // vmode: 0 index pattern, continuous; 1 random data, 50% valid; 2 random data, continuous
  // inj: 0 none; 1 frm_start during burst 1; 2 rst at burst 0 index 20
  task automatic run_frame(input int nsym, input int vmode, input int inj);
    logic [15:0] q[$];
    int fd[$];
    int t0, k, pos, last_end, nacc, exp_s;
    bit prev_en, fin, held;
    logic [15:0] pend;
    k = 0; pos = 0; last_end = -1000; nacc = 0; prev_en = 0; fin = 0; held = 0;
    pend = gen(vmode, 0);
    t0 = cyc;
    frm_start = 1'b1;
    frm_nsym = 8'(nsym);
    map_vld = 1'b0;
    check("idle_busy", busy, 0);
    step();
    frm_start = 1'b0;
    while (!fin && cyc - t0 < 6000) begin
      check("pilot_start", pilot_start, (cyc == t0 + 1 && nsym != 0));
      if (cyc == t0 + 1) check("rdy_init", map_rdy, 0);
      if (cyc == t0 + 2 && nsym != 0) check("rdy_fill", map_rdy, 1);
      if (frm_done) begin
        check("done_time", cyc, nsym == 0 ? t0 + 2 : last_end + GAP + 2);
        check("done_bursts", k, nsym);
        check("done_busy", busy, 0);
        check("done_symcnt", sym_cnt, nsym);
        check("accepted", nacc, nsym * SC);
        fin = 1;
      end else begin
        check("busy", busy, 1);
        if (pilot_en) begin
          if (!prev_en) begin
            exp_s = (k < fd.size()) ? fd[k] + 1 : -1;
            if (k > 0 && k < fd.size() && last_end + GAP + 1 > exp_s) exp_s = last_end + GAP + 1;
            check("burst_start", cyc, exp_s);
            check("sym_cnt_start", sym_cnt, k);
            pos = 0;
          end
          check("index", pilot_index, pos);
          check("data", {pilot_din_re, pilot_din_im}, (k * SC + pos < q.size()) ? {16'd0, q[k*SC+pos]} : 32'h1_0000);
          check("rdy_burst", map_rdy, OVL && nacc < nsym * SC && nacc < (k + 2) * SC);
          if (inj == 2 && k == 0 && pos == 20) begin
            rst = 1'b1;
            step();
            chk_zero("rst_mid");
            rst = 1'b0;
            map_vld = 1'b0;
            step();
            return;
          end
          pos++;
        end else if (prev_en) begin
          check("burst_len", pos, SC);
          last_end = cyc - 1;
          k++;
          check("sym_cnt_end", sym_cnt, k);
        end
        prev_en = pilot_en;
        frm_start = inj == 1 && k == 1 && pilot_en && pos == 11;
        frm_nsym = frm_start ? 8'd7 : 8'(nsym);
        map_vld = (vmode == 1 && !held) ? 1'($urandom_range(0, 1)) : 1'b1;
        {map_re, map_im} = pend;
        if (map_vld && map_rdy) begin
          q.push_back(pend);
          nacc++;
          if (nacc % SC == 0) fd.push_back(cyc);
          pend = gen(vmode, nacc);
          held = 0;
        end else held = map_vld;
        step();
      end
    end
    check("frm_done_seen", fin, 1);
    if (fin) begin
      frm_start = 1'b1;
      frm_nsym = 8'd1;
      map_vld = 1'b0;
      step();
      frm_start = 1'b0;
      check("start_at_done", {busy, pilot_start}, 0);
      check("rdy_idle", map_rdy, 0);
    end
  endtask
  initial begin
    rst = 1'b1;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    run_frame(1, 0, 0);
    run_frame(3, 1, 0);
    run_frame(0, 1, 0);
    run_frame(2, 1, 1);
    run_frame(2, 2, 2);
    run_frame(1, 0, 0);
    run_frame(4, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
